// File: rtl/tree_adder_pkg.sv
// tree_adder_pkg
//   Shared definitions for the pipelined signed reduction adder:
//   - default width constants
//   - beat_sb_t : per-beat sideband (first/last) carried beside the tree data
//   - clog2     : ceiling log2, used for the number of tree levels
//   - lvl_off   : bit offset of tree level j inside the flattened level bus
//   - sat_signed: clamp a signed value to an out_w-bit signed range
package tree_adder_pkg;

  localparam int DEF_N_IN  = 32;
  localparam int DEF_IN_W  = 16;
  localparam int DEF_OUT_W = 16;

  typedef struct packed {
    logic first;
    logic last;
  } beat_sb_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Level i of the tree is (n_in >> i) lanes of (in_w + i) bits; level 0 is the
  // raw input. All levels are packed back to back, level 0 at the bottom.
  function automatic int lvl_off(input int n_in, input int in_w, input int j);
    int off;
    off = 0;
    for (int i = 0; i < j; i++) off += (n_in >> i) * (in_w + i);
    return off;
  endfunction

  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                    input int                 out_w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/tree_adder_level.sv
// tree_adder_level
//   One registered level of the reduction tree: PAIRS independent adders, each
//   summing two adjacent W-bit signed lanes into a W+1-bit signed result, so no
//   bits are ever dropped. Data registers carry no reset; validity travels in
//   the parent's sideband pipe.
// Ports:
//   clk  - clock
//   en   - load enable (pipeline advance)
//   in   - 2*PAIRS lanes of W bits, lane k at [k*W +: W]
//   out  - PAIRS sums of W+1 bits, sum p at [p*(W+1) +: W+1]
module tree_adder_level
  import tree_adder_pkg::*;
#(
  parameter int PAIRS = 1,
  parameter int W     = 16
) (
  input  logic                   clk,
  input  logic                   en,
  input  logic [2*PAIRS*W-1:0]   in,
  output logic [PAIRS*(W+1)-1:0] out
);

  for (genvar p = 0; p < PAIRS; p++) begin : g_pair
    logic signed [W-1:0] a, b;
    logic signed [W:0]   s_q;

    assign a = in[(2*p)*W   +: W];
    assign b = in[(2*p+1)*W +: W];

    // Size casts on signed operands sign-extend before the add.
    always_ff @(posedge clk) begin
      if (en) s_q <= (W+1)'(a) + (W+1)'(b);
    end

    assign out[p*(W+1) +: W+1] = s_q;
  end

endmodule

// File: rtl/pipelined_tree_adder.sv
// pipelined_tree_adder
//   Pipelined signed reduction of N_IN lanes per beat, followed by an
//   accumulate stage so one dot product may span several beats (in_first ..
//   in_last). L = clog2(N_IN) registered tree levels plus one accumulate stage
//   give L+1 cycles from an accepted last beat to out_valid.
//   The whole pipe advances together: adv = ~out_valid | out_ready, and
//   in_ready = adv. When adv is low every register, including acc, holds.
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   in_valid/in_ready   - input handshake
//   in_data             - N_IN signed lanes, lane k at [k*IN_W +: IN_W]
//   in_first, in_last   - beat starts / ends a sum
//   out_valid/out_ready - output handshake
//   out_data            - formatted sum (clamped when SAT, else low OUT_W bits)
//   ACC_W must not exceed 64.
module pipelined_tree_adder
  import tree_adder_pkg::*;
#(
  parameter int N_IN  = DEF_N_IN,
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int ACC_W = IN_W + clog2(N_IN) + 4,
  parameter bit SAT   = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_IN*IN_W-1:0]   in_data,
  input  logic                   in_first,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_data
);

  localparam int L     = clog2(N_IN);
  localparam int TW    = IN_W + L;
  localparam int BUS_W = lvl_off(N_IN, IN_W, L + 1);

  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  // ---------------------------------------------------------------------------
  // Reduction tree. Every level lives in one flat bus; level j reads slice j-1
  // and writes slice j, so the widths line up without hierarchical references.
  // ---------------------------------------------------------------------------
  wire [BUS_W-1:0] tree_bus;
  assign tree_bus[N_IN*IN_W-1:0] = in_data;

  for (genvar j = 1; j <= L; j++) begin : g_lvl
    localparam int PW = IN_W + j - 1;
    localparam int PR = N_IN >> j;

    tree_adder_level #(
      .PAIRS (PR),
      .W     (PW)
    ) u_lvl (
      .clk (clk),
      .en  (adv),
      .in  (tree_bus[lvl_off(N_IN, IN_W, j-1) +: 2*PR*PW]),
      .out (tree_bus[lvl_off(N_IN, IN_W, j)   +: PR*(PW+1)])
    );
  end

  logic signed [TW-1:0] tree_out;
  assign tree_out = tree_bus[lvl_off(N_IN, IN_W, L) +: TW];

  // ---------------------------------------------------------------------------
  // Sideband pipe: entry i travels with tree level i+1. Only the valid bits
  // need a reset; first/last are cleared too so the pipe restarts clean.
  // ---------------------------------------------------------------------------
  logic     [L-1:0] vld_pipe;
  beat_sb_t [L-1:0] sb_pipe;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      sb_pipe  <= '0;
    end else if (adv) begin
      vld_pipe[0] <= in_valid;
      sb_pipe[0]  <= '{first: in_first, last: in_last};
      for (int i = 1; i < L; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        sb_pipe[i]  <= sb_pipe[i-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Accumulate / output stage.
  // after_last forces a fresh start on the first beat after reset or after a
  // completed sum, so a missing in_first cannot leak an old partial sum.
  // ---------------------------------------------------------------------------
  logic signed [ACC_W-1:0] acc, base, sum;
  logic signed [63:0]      sum64;
  logic        [OUT_W-1:0] fmt;
  logic                    after_last;
  logic                    beat_vld;
  beat_sb_t                beat_sb;

  assign beat_vld = vld_pipe[L-1];
  assign beat_sb  = sb_pipe[L-1];

  always_comb begin
    base  = (beat_sb.first || after_last) ? '0 : acc;
    sum   = base + ACC_W'(tree_out);   // wraps at ACC_W by design
    sum64 = 64'(sum);
    fmt   = SAT ? OUT_W'(sat_signed(sum64, OUT_W)) : OUT_W'(sum64);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc        <= '0;
      after_last <= 1'b1;
      out_valid  <= 1'b0;
      out_data   <= '0;
    end else if (adv) begin
      // adv implies any held result is consumed this cycle; it is replaced
      // only when a last beat arrives, otherwise out_valid drops.
      out_valid <= beat_vld & beat_sb.last;
      if (beat_vld) begin
        if (beat_sb.last) begin
          out_data   <= fmt;
          acc        <= '0;
          after_last <= 1'b1;
        end else begin
          acc        <= sum;
          after_last <= 1'b0;
        end
      end
    end
  end

endmodule
